// File: rtl/seq_divider_qr.sv
// seq_divider_qr: multi-cycle radix-2 restoring divider producing quotient and remainder,
// signed (truncating) or unsigned per operation. Optional macro DIV_ZERO_FLAG_EN adds div_by_zero.
module seq_divider_qr #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH + 1)
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  start,
    input  logic                  is_signed,
    input  logic [DATA_WIDTH-1:0] Operand1,
    input  logic [DATA_WIDTH-1:0] Operand2,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder,
    output logic                  busy,
    output logic                  done
`ifdef DIV_ZERO_FLAG_EN
    ,
    output logic                  div_by_zero
`endif
);
    localparam int W = DATA_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    // Magnitude of x when treated as two's complement; |MIN| = 2^(W-1) fits unsigned.
    function automatic logic [W-1:0] magnitude(input logic [W-1:0] x, input logic sgn);
        logic [W-1:0] m;
        if (sgn && x[W-1]) begin
            m = -x;
        end else begin
            m = x;
        end
        return m;
    endfunction

    function automatic logic [W-1:0] apply_sign(input logic [W-1:0] x, input logic neg);
        logic [W-1:0] v;
        if (neg) begin
            v = -x;
        end else begin
            v = x;
        end
        return v;
    endfunction

    state_t               state_r;
    state_t               state_nxt_s;
    logic [CNT_WIDTH-1:0] cnt_r;
    logic [W-1:0]         rem_r;
    logic [W-1:0]         dvd_r;
    logic [W-1:0]         bmag_r;
    logic [W-1:0]         a_raw_r;
    logic                 b_zero_r;
    logic                 sign_q_r;
    logic                 sign_r_r;
    logic [W-1:0]         quotient_r;
    logic [W-1:0]         remainder_r;
    logic                 busy_r;
    logic                 done_r;
    logic [W:0]           shifted_s;
    logic [W:0]           diff_s;
`ifdef DIV_ZERO_FLAG_EN
    logic                 dbz_r;
`endif

    // Trial subtraction for one restoring iteration; diff_s[W] is the borrow.
    always_comb begin
        shifted_s = {rem_r, dvd_r[W-1]};
        diff_s    = shifted_s - {1'b0, bmag_r};
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
`ifdef DIV_ZERO_FLAG_EN
                    if (Operand2 == {W{1'b0}}) begin
                        state_nxt_s = ST_FIX;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
`else
                    state_nxt_s = ST_RUN;
`endif
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (cnt_r == CNT_WIDTH'(1)) begin
                    state_nxt_s = ST_FIX;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_FIX:  state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand capture, iteration datapath and registered results
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt_r       <= {CNT_WIDTH{1'b0}};
            rem_r       <= {W{1'b0}};
            dvd_r       <= {W{1'b0}};
            bmag_r      <= {W{1'b0}};
            a_raw_r     <= {W{1'b0}};
            b_zero_r    <= 1'b0;
            sign_q_r    <= 1'b0;
            sign_r_r    <= 1'b0;
            quotient_r  <= {W{1'b0}};
            remainder_r <= {W{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
            dbz_r       <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            busy_r <= (state_nxt_s != ST_IDLE);
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        a_raw_r  <= Operand1;
                        b_zero_r <= (Operand2 == {W{1'b0}});
                        sign_q_r <= is_signed & (Operand1[W-1] ^ Operand2[W-1]);
                        sign_r_r <= is_signed & Operand1[W-1];
                        dvd_r    <= magnitude(Operand1, is_signed);
                        bmag_r   <= magnitude(Operand2, is_signed);
                        rem_r    <= {W{1'b0}};
                        cnt_r    <= CNT_WIDTH'(W);
                    end
                end
                ST_RUN: begin
                    // Quotient bits shift into dvd_r as the dividend bits shift out.
                    if (!diff_s[W]) begin
                        rem_r <= diff_s[W-1:0];
                    end else begin
                        rem_r <= shifted_s[W-1:0];
                    end
                    dvd_r <= {dvd_r[W-2:0], ~diff_s[W]};
                    cnt_r <= cnt_r - CNT_WIDTH'(1);
                end
                ST_FIX: begin
                    if (b_zero_r) begin
                        quotient_r  <= {W{1'b1}};
                        remainder_r <= a_raw_r;
                    end else begin
                        quotient_r  <= apply_sign(dvd_r, sign_q_r);
                        remainder_r <= apply_sign(rem_r, sign_r_r);
                    end
                    done_r <= 1'b1;
`ifdef DIV_ZERO_FLAG_EN
                    dbz_r  <= b_zero_r;
`endif
                end
                default: begin
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign quotient  = quotient_r;
    assign remainder = remainder_r;
    assign busy      = busy_r;
    assign done      = done_r;
`ifdef DIV_ZERO_FLAG_EN
    assign div_by_zero = dbz_r;
`endif

endmodule

// File: tb/tb_seq_divider_qr.sv
// Directed testbench for seq_divider_qr at DATA_WIDTH=6; outputs sampled at the falling edge.
module tb_seq_divider_qr;
    localparam int W = 6;

    logic         CLK = 1'b0;
    logic         RST;
    logic         start;
    logic         is_signed;
    logic [W-1:0] Operand1;
    logic [W-1:0] Operand2;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         busy;
    logic         done;
`ifdef DIV_ZERO_FLAG_EN
    logic         div_by_zero;
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 7;
`endif

    int errors = 0;
    int checks = 0;

    seq_divider_qr #(.DATA_WIDTH(W)) dut (
        .CLK(CLK), .RST(RST), .start(start), .is_signed(is_signed),
        .Operand1(Operand1), .Operand2(Operand2),
        .quotient(quotient), .remainder(remainder), .busy(busy), .done(done)
`ifdef DIV_ZERO_FLAG_EN
        , .div_by_zero(div_by_zero)
`endif
    );

    always #5 CLK = ~CLK;

    // Issue one operation, then scramble the operand inputs; returns cycles from start edge to done.
    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                         output int lat, output int busy_cyc);
        @(negedge CLK);
        start = 1'b1; Operand1 = a; Operand2 = b; is_signed = sgn;
        @(posedge CLK);
        @(negedge CLK);
        start = 1'b0; Operand1 = ~a; Operand2 = b + 6'd1; is_signed = ~sgn;
        lat = -1; busy_cyc = 0;
        for (int k = 0; k < 30; k++) begin
            if (done === 1'b1) begin lat = k; break; end
            if (busy === 1'b1) busy_cyc++;
            @(negedge CLK);
        end
    endtask

    task automatic test_reset();
        RST = 1'b0; start = 1'b0; is_signed = 1'b0; Operand1 = '0; Operand2 = '0;
        repeat (2) @(negedge CLK);
        checks++; if (quotient !== 6'd0) begin errors++; $display("FAIL reset_q got=%0d exp=0", quotient); end
        checks++; if (remainder !== 6'd0) begin errors++; $display("FAIL reset_r got=%0d exp=0", remainder); end
        checks++; if ({busy, done} !== 2'b00) begin errors++; $display("FAIL reset_busy_done got=%b exp=00", {busy, done}); end
`ifdef DIV_ZERO_FLAG_EN
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero); end
`endif
        RST = 1'b1;
    endtask

    task automatic test_unsigned_basic();
        int lat, bc;
        do_op(6'd21, 6'd7, 1'b0, lat, bc);
        checks++; if (lat !== 7) begin errors++; $display("FAIL u21_7_latency got=%0d exp=7", lat); end
        checks++; if (bc !== 7) begin errors++; $display("FAIL u21_7_busy_cycles got=%0d exp=7", bc); end
        checks++; if (quotient !== 6'd3) begin errors++; $display("FAIL u21_7_q got=%0d exp=3", quotient); end
        checks++; if (remainder !== 6'd0) begin errors++; $display("FAIL u21_7_r got=%0d exp=0", remainder); end
        @(negedge CLK);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL u21_7_done_pulse got=%b exp=0", done); end
        checks++; if ({quotient, remainder} !== {6'd3, 6'd0}) begin errors++; $display("FAIL u21_7_hold got=%0d/%0d exp=3/0", quotient, remainder); end
    endtask

    task automatic test_signed();
        int lat, bc;
        do_op(6'd43, 6'd4, 1'b1, lat, bc);
        checks++; if (lat !== 7) begin errors++; $display("FAIL s43_4_latency got=%0d exp=7", lat); end
        checks++; if ({quotient, remainder} !== {6'd59, 6'd63}) begin errors++; $display("FAIL s43_4_qr got=%0d/%0d exp=59/63", quotient, remainder); end
        do_op(6'd44, 6'd3, 1'b1, lat, bc);
        checks++; if ({quotient, remainder} !== {6'd58, 6'd62}) begin errors++; $display("FAIL s44_3_qr got=%0d/%0d exp=58/62", quotient, remainder); end
        do_op(6'd20, 6'd61, 1'b1, lat, bc);
        checks++; if ({quotient, remainder} !== {6'd58, 6'd2}) begin errors++; $display("FAIL s20_61_qr got=%0d/%0d exp=58/2", quotient, remainder); end
    endtask

    task automatic test_unsigned_more();
        int lat, bc;
        do_op(6'd43, 6'd4, 1'b0, lat, bc);
        checks++; if ({quotient, remainder} !== {6'd10, 6'd3}) begin errors++; $display("FAIL u43_4_qr got=%0d/%0d exp=10/3", quotient, remainder); end
        do_op(6'd63, 6'd1, 1'b0, lat, bc);
        checks++; if ({quotient, remainder} !== {6'd63, 6'd0}) begin errors++; $display("FAIL u63_1_qr got=%0d/%0d exp=63/0", quotient, remainder); end
    endtask

    task automatic test_overflow();
        int lat, bc;
        do_op(6'd32, 6'd63, 1'b1, lat, bc);
        checks++; if ({quotient, remainder} !== {6'd32, 6'd0}) begin errors++; $display("FAIL s32_63_qr got=%0d/%0d exp=32/0", quotient, remainder); end
    endtask

    task automatic test_div_zero();
        int lat, bc;
        for (int m = 0; m < 2; m++) begin
            do_op(6'd21, 6'd0, m[0], lat, bc);
            checks++; if (lat !== ZLAT) begin errors++; $display("FAIL dz21_latency mode=%0d got=%0d exp=%0d", m, lat, ZLAT); end
            checks++; if ({quotient, remainder} !== {6'd63, 6'd21}) begin errors++; $display("FAIL dz21_qr mode=%0d got=%0d/%0d exp=63/21", m, quotient, remainder); end
`ifdef DIV_ZERO_FLAG_EN
            checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dz21_flag mode=%0d got=%b exp=1", m, div_by_zero); end
`endif
        end
        do_op(6'd43, 6'd0, 1'b1, lat, bc);
        checks++; if ({quotient, remainder} !== {6'd63, 6'd43}) begin errors++; $display("FAIL dz43_s_qr got=%0d/%0d exp=63/43", quotient, remainder); end
        do_op(6'd21, 6'd7, 1'b0, lat, bc);
        checks++; if (quotient !== 6'd3) begin errors++; $display("FAIL after_dz_q got=%0d exp=3", quotient); end
`ifdef DIV_ZERO_FLAG_EN
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL dz_flag_clear got=%b exp=0", div_by_zero); end
`endif
    endtask

    task automatic test_start_ignored();
        int lat, nd;
        @(negedge CLK);
        start = 1'b1; Operand1 = 6'd43; Operand2 = 6'd4; is_signed = 1'b1;
        @(posedge CLK);
        @(negedge CLK); start = 1'b0;
        repeat (2) @(negedge CLK);
        start = 1'b1; Operand1 = 6'd21; Operand2 = 6'd7; is_signed = 1'b0;
        @(negedge CLK); start = 1'b0;
        lat = -1;
        for (int k = 3; k < 30; k++) begin
            if (done === 1'b1) begin lat = k; break; end
            @(negedge CLK);
        end
        checks++; if (lat !== 7) begin errors++; $display("FAIL ignore_latency got=%0d exp=7", lat); end
        checks++; if ({quotient, remainder} !== {6'd59, 6'd63}) begin errors++; $display("FAIL ignore_qr got=%0d/%0d exp=59/63", quotient, remainder); end
        nd = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge CLK);
            if (done === 1'b1 || busy === 1'b1) nd++;
        end
        checks++; if (nd !== 0) begin errors++; $display("FAIL ignore_no_second_op got=%0d exp=0", nd); end
    endtask

    task automatic test_reset_mid_op();
        int lat, bc, nd;
        @(negedge CLK);
        start = 1'b1; Operand1 = 6'd21; Operand2 = 6'd7; is_signed = 1'b0;
        @(posedge CLK);
        @(negedge CLK); start = 1'b0;
        repeat (4) @(negedge CLK);
        RST = 1'b0;
        #1;
        checks++; if ({quotient, remainder, busy, done} !== 14'd0) begin errors++; $display("FAIL midreset_outputs got=%0d/%0d/%b/%b exp=0/0/0/0", quotient, remainder, busy, done); end
        nd = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge CLK);
            if (k == 2) RST = 1'b1;
            if (done === 1'b1 || busy === 1'b1) nd++;
        end
        checks++; if (nd !== 0) begin errors++; $display("FAIL midreset_no_done got=%0d exp=0", nd); end
        do_op(6'd30, 6'd4, 1'b0, lat, bc);
        checks++; if (lat !== 7) begin errors++; $display("FAIL post_reset_latency got=%0d exp=7", lat); end
        checks++; if ({quotient, remainder} !== {6'd7, 6'd2}) begin errors++; $display("FAIL post_reset_qr got=%0d/%0d exp=7/2", quotient, remainder); end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        do_op(6'd21, 6'd7, 1'b0, lat, bc);
        checks++; if (quotient !== 6'd3) begin errors++; $display("FAIL b2b_first_q got=%0d exp=3", quotient); end
        start = 1'b1; Operand1 = 6'd43; Operand2 = 6'd4; is_signed = 1'b0;
        @(posedge CLK);
        @(negedge CLK); start = 1'b0;
        lat = -1;
        for (int k = 0; k < 30; k++) begin
            if (done === 1'b1) begin lat = k; break; end
            @(negedge CLK);
        end
        checks++; if (lat !== 7) begin errors++; $display("FAIL b2b_latency got=%0d exp=7", lat); end
        checks++; if ({quotient, remainder} !== {6'd10, 6'd3}) begin errors++; $display("FAIL b2b_second_qr got=%0d/%0d exp=10/3", quotient, remainder); end
    endtask

    initial begin
        test_reset();
        test_unsigned_basic();
        test_signed();
        test_unsigned_more();
        test_overflow();
        test_div_zero();
        test_start_ignored();
        test_reset_mid_op();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation timeout");
    end
endmodule

// File: doc/seq_divider_qr.md
Name: seq_divider_qr

Overview:
- Multi-cycle radix-2 restoring divider, the parametrised successor of the processor's single-result divider.
- Returns both quotient and remainder.
- Supports signed (truncating, MIPS DIV) and unsigned (DIVU) modes, selected per operation.
- Sits in the multi-cycle datapath as the HI/LO producer; the control FSM issues start and waits on done.

Parameters:
- DATA_WIDTH, 32: operand and result width in bits (W); must be >= 2.
- CNT_WIDTH, $clog2(DATA_WIDTH+1): iteration counter width; derived, do not override.

Ports:
- CLK  input  1  clock, rising-edge active.
- RST  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- is_signed  input  1  1 = two's-complement divide, 0 = unsigned; captured with start.
- Operand1  input  W  dividend; captured with start.
- Operand2  input  W  divisor; captured with start.
- quotient  output  W  registered quotient; holds until the next completion.
- remainder  output  W  registered remainder; holds until the next completion.
- busy  output  1  high while an operation is in flight (RUN or FIX).
- done  output  1  one-cycle completion pulse, coincident with new quotient/remainder.
- div_by_zero  output  1  only when DIV_ZERO_FLAG_EN is defined (see Optional Feature).

Behaviour:
- Reset (RST=0, any time, including mid-operation):
  - state=IDLE; quotient, remainder, busy, done, div_by_zero all 0.
  - Any in-flight operation is discarded.
- States: IDLE, RUN, FIX.
- IDLE:
  - On an edge with start=1: capture operands, is_signed, sign_q = signed & (a[W-1]^b[W-1]), sign_r = signed & a[W-1].
  - Load |a| and |b| (magnitudes only when signed), clear the partial remainder, counter=W, go to RUN, busy=1.
  - start=0: stay in IDLE.
- RUN:
  - One iteration per cycle: shift {rem, dvd} left 1, trial subtract |b| from rem.
  - If the result is non-negative, keep it and set quotient bit 1; else restore and set the bit to 0.
  - Counter decrements; after W iterations go to FIX.
- FIX (1 cycle):
  - quotient = sign_q ? -q : q; remainder = sign_r ? -r : r; done=1 (registered).
  - busy=0; next state IDLE.
- Latency: start sampled at edge T0 -> done high during the cycle after edge T0+W+1 (W+1 cycles).
- start while busy=1 is ignored (not queued). Operand changes after capture are ignored.
- Back-to-back: start may be high in the done cycle; it is accepted at the next edge.
- The remainder sign follows the dividend; |remainder| < |divisor|.
- Overflow, signed MIN / -1: quotient = MIN (wraps), remainder = 0, no flag.
- Divide by zero, both modes: quotient = all ones, remainder = Operand1 unmodified.
  - This applies in both builds.
  - Without the macro, full W+1 latency.
- Internal width: the partial remainder is W+1 bits so the trial subtract never loses the borrow.
- Unsigned |a| = a; signed |MIN| = 2^(W-1), representable in the W-bit unsigned magnitude path.

Optional Feature:
- Macro DIV_ZERO_FLAG_EN.
- Defined:
  - div_by_zero output port exists.
  - Operand2==0 at start goes IDLE -> FIX directly, loading the fixed divide-by-zero results.
  - done and div_by_zero=1 are high in the cycle after edge T0+1 (latency 1).
  - div_by_zero has the same hold semantics as quotient and is cleared on the next completion.
- Not defined: no port; divide by zero takes the normal W+1 cycles with the same fixed results.

Test Plan (DATA_WIDTH=6, all checks at negedge):
- Reset, then start with is_signed=0, 21 / 7:
  - busy=1 for 7 cycles; done pulses exactly 7 cycles after the start edge.
  - quotient=3, remainder=0; outputs hold after done drops.
- is_signed=1, 43 (-21) / 4:
  - quotient=59 (-5), remainder=63 (-1).
- Same operands, 43 / 4 with is_signed=0:
  - quotient=10, remainder=3.
- is_signed=1, 32 (-32) / 63 (-1):
  - quotient=32 (-32), remainder=0.
- 21 / 0, both modes:
  - quotient=63, remainder=21.
  - Without the macro: done after 7 cycles.
  - With DIV_ZERO_FLAG_EN: done and div_by_zero after 1 cycle; the next nonzero divide clears div_by_zero.
- Mid-operation events:
  - Pulse start again 3 cycles into a divide: ignored, first result correct.
  - Assert RST=0 at cycle 4 of a divide: all outputs 0, no done; a new divide 30/4 gives quotient=7, remainder=2.
  - Start held high during the done cycle: second operation completes 7 cycles later.
